icache: RTL and testbench

Direct-mapped instruction cache between the fetcher and the memory controller's instruction-read port. It returns hits one cycle after a request. On a miss it refills a whole 16-byte line with four sequential word reads, then answers the pending fetch. A ROB misbranch aborts any in-flight request; partially refilled lines are never installed.

---
 rtl/icache.sv | 152 +++++++++++++++
 tb/tb_icache.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// +--------------------------------------------------------------------------+
// | icache : direct-mapped instruction cache, 16-byte lines, 4-word refill   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_fetcher_ce,
  input  logic [31:0] in_fetcher_pc,
  output logic        out_fetcher_ce,
  output logic [31:0] out_fetcher_instr,
  output logic        out_mem_ce,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_ce,
  input  logic [31:0] in_mem_data,
  input  logic        in_rob_misbranch
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [1:0]             cnt_q;
  logic [27:0]            line_q;
  logic [1:0]             off_q;
  logic [2:0][31:0]       buf_q;
  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [3:0][31:0]       data_q [LINES];
  logic                   fetch_ce_q;
  logic [31:0]            fetch_instr_q;
  logic                   mem_ce_q;
  logic [31:0]            mem_addr_q;

  logic [INDEX_BITS-1:0]  w_req_idx;
  logic [TAG_W-1:0]       w_req_tag;
  logic [1:0]             w_req_off;
  logic                   w_hit;
  logic [INDEX_BITS-1:0]  w_fill_idx;
  logic [TAG_W-1:0]       w_fill_tag;
  logic                   w_fill_done;
  logic [31:0]            w_fill_word;
  logic                   unused_pc_bits;

  assign w_req_idx   = in_fetcher_pc[4+INDEX_BITS-1:4];
  assign w_req_tag   = in_fetcher_pc[31:4+INDEX_BITS];
  assign w_req_off   = in_fetcher_pc[3:2];
  assign w_hit       = valid_q[w_req_idx] && (tag_q[w_req_idx] == w_req_tag);
  assign w_fill_idx  = line_q[INDEX_BITS-1:0];
  assign w_fill_tag  = line_q[27:INDEX_BITS];
  assign w_fill_done = (state_q == S_REQ) && in_mem_ce && (cnt_q == 2'd3) && !in_rob_misbranch;
  assign unused_pc_bits = ^in_fetcher_pc[1:0];

  // The last word is forwarded straight from memory; it is not in the buffer yet.
  always_comb begin
    w_fill_word = in_mem_data;
    case (off_q)
      2'd0:    w_fill_word = buf_q[0];
      2'd1:    w_fill_word = buf_q[1];
      2'd2:    w_fill_word = buf_q[2];
      default: w_fill_word = in_mem_data;
    endcase
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (rdy && w_fill_done) begin
      tag_q[w_fill_idx]  <= w_fill_tag;
      data_q[w_fill_idx] <= {in_mem_data, buf_q[2], buf_q[1], buf_q[0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 2'd0;
      line_q        <= '0;
      off_q         <= 2'd0;
      buf_q         <= '0;
      valid_q       <= '0;
      fetch_ce_q    <= 1'b0;
      fetch_instr_q <= 32'd0;
      mem_ce_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
    end else if (rdy) begin
      fetch_ce_q <= 1'b0;
      if (in_rob_misbranch) begin
        state_q  <= S_IDLE;
        mem_ce_q <= 1'b0;
        cnt_q    <= 2'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (in_fetcher_ce && !fetch_ce_q) begin
              if (w_hit) begin
                fetch_ce_q    <= 1'b1;
                fetch_instr_q <= data_q[w_req_idx][w_req_off];
              end else begin
                line_q     <= in_fetcher_pc[31:4];
                off_q      <= w_req_off;
                cnt_q      <= 2'd0;
                mem_ce_q   <= 1'b1;
                mem_addr_q <= {in_fetcher_pc[31:4], 4'b0000};
                state_q    <= S_REQ;
              end
            end
          end
          S_REQ: begin
            if (in_mem_ce) begin
              mem_ce_q <= 1'b0;
              if (cnt_q == 2'd3) begin
                valid_q[w_fill_idx] <= 1'b1;
                fetch_ce_q          <= 1'b1;
                fetch_instr_q       <= w_fill_word;
                state_q             <= S_IDLE;
              end else begin
                buf_q[cnt_q] <= in_mem_data;
                cnt_q        <= cnt_q + 2'd1;
                state_q      <= S_GAP;
              end
            end
          end
          S_GAP: begin
            mem_ce_q   <= 1'b1;
            mem_addr_q <= {line_q, cnt_q, 2'b00};
            state_q    <= S_REQ;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign out_fetcher_ce    = fetch_ce_q;
  assign out_fetcher_instr = fetch_instr_q;
  assign out_mem_ce        = mem_ce_q;
  assign out_mem_addr      = mem_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// +--------------------------------------------------------------------------+
// | tb_icache : directed self-checking bench for icache                      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_fetcher_ce;
  logic [31:0] in_fetcher_pc;
  logic        out_fetcher_ce;
  logic [31:0] out_fetcher_instr;
  logic        out_mem_ce;
  logic [31:0] out_mem_addr;
  logic        in_mem_ce;
  logic [31:0] in_mem_data;
  logic        in_rob_misbranch;

  int checks = 0;
  int errors = 0;

  icache #(.INDEX_BITS(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .in_fetcher_ce     (in_fetcher_ce),
    .in_fetcher_pc     (in_fetcher_pc),
    .out_fetcher_ce    (out_fetcher_ce),
    .out_fetcher_instr (out_fetcher_instr),
    .out_mem_ce        (out_mem_ce),
    .out_mem_addr      (out_mem_addr),
    .in_mem_ce         (in_mem_ce),
    .in_mem_data       (in_mem_data),
    .in_rob_misbranch  (in_rob_misbranch)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Memory contents: upper half 0xCAFE, lower half the byte address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return {16'hCAFE, a[15:0]};
  endfunction

  task automatic start_fetch(input logic [31:0] pc);
    in_fetcher_ce = 1'b1;
    in_fetcher_pc = pc;
  endtask

  task automatic wait_mem_req(output logic ok, output logic [31:0] addr);
    ok   = 1'b0;
    addr = 32'd0;
    for (int i = 0; i < 50; i++) begin
      if (out_mem_ce === 1'b1) begin
        ok   = 1'b1;
        addr = out_mem_addr;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic mem_respond(input logic [31:0] data, input int lat, input logic mb);
    repeat (lat) @(negedge clk);
    in_mem_ce        = 1'b1;
    in_mem_data      = data;
    in_rob_misbranch = mb;
    if (mb) in_fetcher_ce = 1'b0;
    @(negedge clk);
    in_mem_ce        = 1'b0;
    in_rob_misbranch = 1'b0;
  endtask

  task automatic do_refill(input logic [31:0] base, input int lat, output int addr_err,
                           output int gap_err, output logic pulse, output logic [31:0] instr);
    logic        ok;
    logic [31:0] a;
    addr_err = 0;
    gap_err  = 0;
    pulse    = 1'b0;
    instr    = 32'd0;
    for (int w = 0; w < 4; w++) begin
      wait_mem_req(ok, a);
      if (!ok || a !== base + 32'(4 * w)) addr_err++;
      mem_respond(memword(base + 32'(4 * w)), lat, 1'b0);
      if (w < 3 && out_mem_ce !== 1'b0) gap_err++;
      if (w < 3 && out_fetcher_ce !== 1'b0) gap_err++;
      if (w == 3) begin
        pulse = out_fetcher_ce;
        instr = out_fetcher_instr;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (out_fetcher_ce !== 1'b0) begin errors++; $display("FAIL reset_fetch_ce got %0b want 0", out_fetcher_ce); end
    checks++;
    if (out_fetcher_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", out_fetcher_instr); end
    checks++;
    if (out_mem_ce !== 1'b0) begin errors++; $display("FAIL reset_mem_ce got %0b want 0", out_mem_ce); end
    checks++;
    if (out_mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", out_mem_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_mem_ce !== 1'b0 || out_fetcher_ce !== 1'b0) begin
      errors++; $display("FAIL reset_idle got mem_ce=%0b fetch_ce=%0b want 0 0", out_mem_ce, out_fetcher_ce);
    end
  endtask

  task automatic test_cold_miss;
    int ae, ge; logic p; logic [31:0] ins;
    start_fetch(32'h0000_0104);
    do_refill(32'h0000_0100, 2, ae, ge, p, ins);
    in_fetcher_ce = 1'b0;
    checks++;
    if (ae != 0) begin errors++; $display("FAIL cold_addr got %0d bad reads want 0", ae); end
    checks++;
    if (ge != 0) begin errors++; $display("FAIL cold_gap got %0d bad gaps want 0", ge); end
    checks++;
    if (p !== 1'b1 || ins !== 32'hCAFE_0104) begin
      errors++; $display("FAIL cold_pulse got ce=%0b instr=%h want 1 cafe0104", p, ins);
    end
    @(negedge clk);
    checks++;
    if (out_fetcher_ce !== 1'b0 || out_mem_ce !== 1'b0) begin
      errors++; $display("FAIL cold_after got fetch_ce=%0b mem_ce=%0b want 0 0", out_fetcher_ce, out_mem_ce);
    end
  endtask

  task automatic test_hit;
    start_fetch(32'h0000_010C);
    @(negedge clk);
    in_fetcher_ce = 1'b0;
    checks++;
    if (out_mem_ce !== 1'b0) begin errors++; $display("FAIL hit_mem_ce got %0b want 0", out_mem_ce); end
    checks++;
    if (out_fetcher_ce !== 1'b1 || out_fetcher_instr !== 32'hCAFE_010C) begin
      errors++; $display("FAIL hit_pulse got ce=%0b instr=%h want 1 cafe010c", out_fetcher_ce, out_fetcher_instr);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    start_fetch(32'h0000_0108);
    @(negedge clk);
    checks++;
    if (out_fetcher_ce !== 1'b1 || out_fetcher_instr !== 32'hCAFE_0108) begin
      errors++; $display("FAIL b2b_first got ce=%0b instr=%h want 1 cafe0108", out_fetcher_ce, out_fetcher_instr);
    end
    in_fetcher_pc = 32'h0000_0100;
    @(negedge clk);
    checks++;
    if (out_fetcher_ce !== 1'b0) begin errors++; $display("FAIL b2b_noaccept got ce=%0b want 0", out_fetcher_ce); end
    @(negedge clk);
    in_fetcher_ce = 1'b0;
    checks++;
    if (out_fetcher_ce !== 1'b1 || out_fetcher_instr !== 32'hCAFE_0100) begin
      errors++; $display("FAIL b2b_second got ce=%0b instr=%h want 1 cafe0100", out_fetcher_ce, out_fetcher_instr);
    end
    @(negedge clk);
  endtask

  task automatic test_eviction;
    int ae, ge; logic p; logic [31:0] ins;
    start_fetch(32'h0000_0500);
    do_refill(32'h0000_0500, 1, ae, ge, p, ins);
    in_fetcher_ce = 1'b0;
    checks++;
    if (ae != 0 || p !== 1'b1 || ins !== 32'hCAFE_0500) begin
      errors++; $display("FAIL evict_fill got bad=%0d ce=%0b instr=%h want 0 1 cafe0500", ae, p, ins);
    end
    @(negedge clk);
    start_fetch(32'h0000_0100);
    @(negedge clk);
    checks++;
    if (out_mem_ce !== 1'b1 || out_fetcher_ce !== 1'b0) begin
      errors++; $display("FAIL evict_miss got mem_ce=%0b fetch_ce=%0b want 1 0", out_mem_ce, out_fetcher_ce);
    end
    do_refill(32'h0000_0100, 0, ae, ge, p, ins);
    in_fetcher_ce = 1'b0;
    checks++;
    if (ae != 0 || ge != 0 || p !== 1'b1 || ins !== 32'hCAFE_0100) begin
      errors++; $display("FAIL evict_refill got bad=%0d gaps=%0d ce=%0b instr=%h want 0 0 1 cafe0100", ae, ge, p, ins);
    end
    @(negedge clk);
  endtask

  task automatic test_misbranch;
    logic ok; logic [31:0] a; int ae, ge, seen; logic p; logic [31:0] ins;
    start_fetch(32'h0000_0208);
    wait_mem_req(ok, a);
    mem_respond(memword(32'h0000_0200), 1, 1'b0);
    wait_mem_req(ok, a);
    checks++;
    if (!ok || a !== 32'h0000_0204) begin errors++; $display("FAIL mb_second_addr got %h want 00000204", a); end
    mem_respond(memword(32'h0000_0204), 1, 1'b1);
    checks++;
    if (out_mem_ce !== 1'b0 || out_fetcher_ce !== 1'b0) begin
      errors++; $display("FAIL mb_abort got mem_ce=%0b fetch_ce=%0b want 0 0", out_mem_ce, out_fetcher_ce);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_mem_ce !== 1'b0 || out_fetcher_ce !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mb_quiet got %0d active cycles want 0", seen); end
    start_fetch(32'h0000_0208);
    do_refill(32'h0000_0200, 1, ae, ge, p, ins);
    in_fetcher_ce = 1'b0;
    checks++;
    if (ae != 0 || ge != 0 || p !== 1'b1 || ins !== 32'hCAFE_0208) begin
      errors++; $display("FAIL mb_refill got bad=%0d gaps=%0d ce=%0b instr=%h want 0 0 1 cafe0208", ae, ge, p, ins);
    end
    @(negedge clk);
    // Misbranch coinciding with the final word must not install the line.
    start_fetch(32'h0000_030C);
    for (int w = 0; w < 4; w++) begin
      wait_mem_req(ok, a);
      mem_respond(memword(32'h0000_0300 + 32'(4 * w)), 0, (w == 3));
    end
    checks++;
    if (out_fetcher_ce !== 1'b0) begin errors++; $display("FAIL mb_last_pulse got %0b want 0", out_fetcher_ce); end
    @(negedge clk);
    start_fetch(32'h0000_030C);
    @(negedge clk);
    checks++;
    if (out_mem_ce !== 1'b1 || out_fetcher_ce !== 1'b0) begin
      errors++; $display("FAIL mb_last_noinstall got mem_ce=%0b fetch_ce=%0b want 1 0", out_mem_ce, out_fetcher_ce);
    end
    do_refill(32'h0000_0300, 0, ae, ge, p, ins);
    in_fetcher_ce = 1'b0;
    checks++;
    if (ae != 0 || p !== 1'b1 || ins !== 32'hCAFE_030C) begin
      errors++; $display("FAIL mb_last_refill got bad=%0d ce=%0b instr=%h want 0 1 cafe030c", ae, p, ins);
    end
    @(negedge clk);
  endtask

  task automatic test_rdy_stall;
    logic ok; logic [31:0] a; int bad, serr; logic p; logic [31:0] ins;
    bad = 0;
    serr = 0;
    start_fetch(32'h0000_0644);
    wait_mem_req(ok, a);
    if (!ok || a !== 32'h0000_0640) bad++;
    mem_respond(memword(32'h0000_0640), 0, 1'b0);
    wait_mem_req(ok, a);
    if (!ok || a !== 32'h0000_0644) bad++;
    rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_mem_ce   = (s == 1);
      in_mem_data = 32'hDEAD_BEEF;
      @(negedge clk);
      if (out_mem_ce !== 1'b1 || out_mem_addr !== 32'h0000_0644) serr++;
    end
    in_mem_ce = 1'b0;
    rdy = 1'b1;
    checks++;
    if (serr != 0) begin errors++; $display("FAIL stall_frozen got %0d changed cycles want 0", serr); end
    for (int w = 1; w < 4; w++) begin
      wait_mem_req(ok, a);
      if (!ok || a !== 32'h0000_0640 + 32'(4 * w)) bad++;
      mem_respond(memword(32'h0000_0640 + 32'(4 * w)), 1, 1'b0);
    end
    p   = out_fetcher_ce;
    ins = out_fetcher_instr;
    in_fetcher_ce = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_addr got %0d bad reads want 0", bad); end
    checks++;
    if (p !== 1'b1 || ins !== 32'hCAFE_0644) begin
      errors++; $display("FAIL stall_pulse got ce=%0b instr=%h want 1 cafe0644", p, ins);
    end
    @(negedge clk);
    start_fetch(32'h0000_0648);
    @(negedge clk);
    in_fetcher_ce = 1'b0;
    checks++;
    if (out_fetcher_ce !== 1'b1 || out_fetcher_instr !== 32'hCAFE_0648) begin
      errors++; $display("FAIL stall_hit got ce=%0b instr=%h want 1 cafe0648", out_fetcher_ce, out_fetcher_instr);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic ok; logic [31:0] a; int ae, ge; logic p; logic [31:0] ins;
    start_fetch(32'h0000_0108);
    @(negedge clk);
    in_fetcher_ce = 1'b0;
    checks++;
    if (out_fetcher_ce !== 1'b1 || out_fetcher_instr !== 32'hCAFE_0108) begin
      errors++; $display("FAIL areset_prehit got ce=%0b instr=%h want 1 cafe0108", out_fetcher_ce, out_fetcher_instr);
    end
    @(negedge clk);
    start_fetch(32'h0000_0700);
    wait_mem_req(ok, a);
    mem_respond(memword(32'h0000_0700), 0, 1'b0);
    wait_mem_req(ok, a);
    #2 rst = 1'b0;
    #1;
    in_fetcher_ce = 1'b0;
    checks++;
    if (out_mem_ce !== 1'b0 || out_mem_addr !== 32'd0 || out_fetcher_ce !== 1'b0 || out_fetcher_instr !== 32'd0) begin
      errors++; $display("FAIL areset_outputs got mem_ce=%0b addr=%h fetch_ce=%0b instr=%h want all 0",
                         out_mem_ce, out_mem_addr, out_fetcher_ce, out_fetcher_instr);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_fetch(32'h0000_0108);
    @(negedge clk);
    checks++;
    if (out_mem_ce !== 1'b1 || out_fetcher_ce !== 1'b0) begin
      errors++; $display("FAIL areset_miss got mem_ce=%0b fetch_ce=%0b want 1 0", out_mem_ce, out_fetcher_ce);
    end
    do_refill(32'h0000_0100, 0, ae, ge, p, ins);
    in_fetcher_ce = 1'b0;
    checks++;
    if (ae != 0 || p !== 1'b1 || ins !== 32'hCAFE_0108) begin
      errors++; $display("FAIL areset_refill got bad=%0d ce=%0b instr=%h want 0 1 cafe0108", ae, p, ins);
    end
    @(negedge clk);
  endtask

  initial begin
    rst              = 1'b0;
    rdy              = 1'b1;
    in_fetcher_ce    = 1'b0;
    in_fetcher_pc    = 32'd0;
    in_mem_ce        = 1'b0;
    in_mem_data      = 32'd0;
    in_rob_misbranch = 1'b0;
    test_reset;
    test_cold_miss;
    test_hit;
    test_back_to_back;
    test_eviction;
    test_misbranch;
    test_rdy_stall;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
